// File: rtl/game_pkg.sv
// Shared encodings for the battleship game controller: FSM state codes,
// player codes and the turn timer's own state enum.
package game_pkg;

  localparam logic [3:0] S_ATTACK_P1 = 4'h3;
  localparam logic [3:0] S_ATTACK_P2 = 4'h4;
  localparam logic [3:0] S_WAIT      = 4'h5;
  localparam logic [3:0] S_CHECK     = 4'h6;
  localparam logic [3:0] S_RANDOM    = 4'h7;
  localparam logic [3:0] S_GAMEOVER  = 4'h8;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P1     = 2'b01;
  localparam logic [1:0] P2     = 2'b10;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_EXPIRED
  } timer_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler that counts 0..CLK_HZ-1 while enabled and flags
// the terminal count; a synchronous clear returns it to zero.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(CLK_HZ);
  localparam logic [W-1:0] CNT_MAX = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown and active-player tracker: times each attack turn from
// the game FSM's registered state code and reports timeout/current player.
module turn_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fsm_state,
  output logic       timeout,
  output logic [1:0] current_player,
  output logic [4:0] seconds_left,
  output logic       warn,
  output logic       tick_1hz
);

  localparam logic [4:0] TURN_SEC = 5'(TURN_SECONDS);

  timer_state_t state_q, state_d;
  logic [4:0]   sec_q, sec_d;
  logic [1:0]   player_q, player_d;
  logic         tick_q, tick_d;
  logic         in_turn;
  logic         player_change;
  logic         presc_clr;
  logic         presc_en;
  logic         presc_tick;

  assign in_turn = (fsm_state == S_ATTACK_P1) || (fsm_state == S_ATTACK_P2) ||
                   (fsm_state == S_WAIT);

  always_comb begin
    player_d = player_q;
    if (fsm_state == S_ATTACK_P1)      player_d = P1;
    else if (fsm_state == S_ATTACK_P2) player_d = P2;
  end

  assign player_change = (player_d != player_q);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (presc_tick)
  );

  // Leaving the turn outranks a player switch, which outranks a same-edge tick.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    tick_d    = 1'b0;
    presc_clr = 1'b0;
    presc_en  = 1'b0;
    unique case (state_q)
      T_IDLE: begin
        presc_clr = 1'b1;
        sec_d     = TURN_SEC;
        if (in_turn) state_d = T_RUN;
      end
      T_RUN: begin
        if (!in_turn) begin
          state_d   = T_IDLE;
          presc_clr = 1'b1;
          sec_d     = TURN_SEC;
        end else if (player_change) begin
          presc_clr = 1'b1;
          sec_d     = TURN_SEC;
        end else begin
          presc_en = 1'b1;
          if (presc_tick) begin
            tick_d = 1'b1;
            sec_d  = sec_q - 5'd1;
            if (sec_q == 5'd1) state_d = T_EXPIRED;
          end
        end
      end
      T_EXPIRED: begin
        presc_clr = 1'b1;
        sec_d     = 5'd0;
        if (!in_turn) begin
          state_d = T_IDLE;
          sec_d   = TURN_SEC;
        end
      end
      default: begin
        state_d   = T_IDLE;
        presc_clr = 1'b1;
        sec_d     = TURN_SEC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= T_IDLE;
      sec_q    <= TURN_SEC;
      player_q <= P_NONE;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      player_q <= player_d;
      tick_q   <= tick_d;
    end
  end

  assign timeout        = (state_q == T_EXPIRED);
  assign current_player = player_q;
  assign seconds_left   = sec_q;
  assign warn           = (state_q == T_RUN) && (sec_q <= 5'd3);
  assign tick_1hz       = tick_q;

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer with CLK_HZ=4, TURN_SECONDS=3.
module tb_turn_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fsm_state = 4'h0;
  logic       timeout;
  logic [1:0] current_player;
  logic [4:0] seconds_left;
  logic       warn;
  logic       tick_1hz;

  int total = 0;
  int bad   = 0;

  turn_timer #(.CLK_HZ(4), .TURN_SECONDS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .fsm_state      (fsm_state),
    .timeout        (timeout),
    .current_player (current_player),
    .seconds_left   (seconds_left),
    .warn           (warn),
    .tick_1hz       (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // inputs change at negedge, outputs sampled at the following negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected seconds after edge e of a fresh 3 s turn at 4 cycles/s.
  function automatic logic [4:0] exp_sec(input int e);
    if (e >= 13) return 5'd0;
    return 5'(3 - (e - 1) / 4);
  endfunction

  task automatic turn_seq(input logic [3:0] s_odd, input logic [3:0] s_even,
                          input int n, input logic [1:0] exp_pl, input string tag);
    for (int e = 1; e <= n; e++) begin
      fsm_state = (e % 2 == 1) ? s_odd : s_even;
      step();
      chk({tag, "_sec"}, 32'(seconds_left), 32'(exp_sec(e)));
      chk({tag, "_to"},  32'(timeout), 32'(e >= 13));
      chk({tag, "_warn"}, 32'(warn), 32'(e < 13));
      chk({tag, "_tick"}, 32'(tick_1hz), 32'(e == 5 || e == 9 || e == 13));
      chk({tag, "_pl"},  32'(current_player), 32'(exp_pl));
    end
  endtask

  initial begin
    // reset and idle with out-of-turn code
    repeat (2) @(negedge clk);
    chk("rst_pl", 32'(current_player), 32'h0);
    chk("rst_sec", 32'(seconds_left), 32'd3);
    chk("rst_to", 32'(timeout), 32'h0);
    chk("rst_warn", 32'(warn), 32'h0);
    chk("rst_tick", 32'(tick_1hz), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fsm_state = (i % 2 == 0) ? 4'h0 : 4'hA;
      step();
      chk("idle_sec", 32'(seconds_left), 32'd3);
      chk("idle_to", 32'(timeout), 32'h0);
      chk("idle_pl", 32'(current_player), 32'h0);
    end

    // held ATTACK_P1, then leave turn
    turn_seq(4'h3, 4'h3, 14, 2'b01, "held3");
    fsm_state = 4'h0;
    step();
    chk("held3_exit_to", 32'(timeout), 32'h0);
    chk("held3_exit_sec", 32'(seconds_left), 32'd3);

    // 3<->5 toggling must not reload
    turn_seq(4'h3, 4'h5, 14, 2'b01, "alt35");
    fsm_state = 4'h6;
    step();
    chk("alt35_exit_to", 32'(timeout), 32'h0);

    // ATTACK_P2 for 6 edges then CHECK
    for (int e = 1; e <= 6; e++) begin
      fsm_state = 4'h4;
      step();
      chk("p2_sec", 32'(seconds_left), 32'(exp_sec(e)));
      chk("p2_pl", 32'(current_player), 32'h2);
    end
    for (int i = 0; i < 3; i++) begin
      fsm_state = 4'h6;
      step();
      chk("p2chk_sec", 32'(seconds_left), 32'd3);
      chk("p2chk_to", 32'(timeout), 32'h0);
      chk("p2chk_pl", 32'(current_player), 32'h2);
      chk("p2chk_warn", 32'(warn), 32'h0);
    end

    // player switch inside RUN reloads the countdown at edge 7
    for (int e = 1; e <= 12; e++) begin
      fsm_state = (e <= 6) ? 4'h3 : 4'h4;
      step();
      chk("sw_sec", 32'(seconds_left), (e <= 4) ? 32'd3 : (e <= 6) ? 32'd2 :
                                       (e <= 10) ? 32'd3 : 32'd2);
      chk("sw_pl", 32'(current_player), (e <= 6) ? 32'h1 : 32'h2);
    end
    fsm_state = 4'h6;
    step();

    // expire while in WAIT, then RANDOM, then CHECK
    turn_seq(4'h5, 4'h5, 13, 2'b10, "wait5");
    fsm_state = 4'h5;
    step();
    chk("exp_hold_to", 32'(timeout), 32'h1);
    chk("exp_hold_sec", 32'(seconds_left), 32'd0);
    fsm_state = 4'h7;
    step();
    chk("exp_rand_to", 32'(timeout), 32'h0);
    chk("exp_rand_sec", 32'(seconds_left), 32'd3);
    chk("exp_rand_pl", 32'(current_player), 32'h2);
    fsm_state = 4'h6;
    step();
    chk("exp_chk_to", 32'(timeout), 32'h0);
    chk("exp_chk_pl", 32'(current_player), 32'h2);

    // async reset mid-turn at edge 7
    for (int e = 1; e <= 6; e++) begin
      fsm_state = 4'h3;
      step();
    end
    chk("pre_rst_sec", 32'(seconds_left), 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pl", 32'(current_player), 32'h0);
    chk("arst_sec", 32'(seconds_left), 32'd3);
    chk("arst_to", 32'(timeout), 32'h0);
    chk("arst_warn", 32'(warn), 32'h0);
    chk("arst_tick", 32'(tick_1hz), 32'h0);
    @(negedge clk);
    step();
    chk("arst_hold_sec", 32'(seconds_left), 32'd3);
    chk("arst_hold_pl", 32'(current_player), 32'h0);
    rst = 1'b0;
    turn_seq(4'h4, 4'h4, 13, 2'b10, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turn_timer.md
# turn_timer

Per-turn countdown and active-player tracker for the battleship game controller. It watches the registered state code from the game FSM and times each attack turn. It feeds the FSM its `timeout` and `current_player` inputs, and drives a seconds-remaining value to the seven-segment display path.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per second; must be ≥ 2.
- `TURN_SECONDS`, 15: turn length in seconds; range 1–31.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fsm_state`  in  4  registered state code from the game FSM.
- `timeout`  out  1  level; high while the current turn has expired.
- `current_player`  out  2  `00` = none, `01` = player 1, `10` = player 2.
- `seconds_left`  out  5  remaining whole seconds of the current turn.
- `warn`  out  1  high in RUN while `seconds_left` ≤ 3.
- `tick_1hz`  out  1  one-cycle pulse on each second boundary while in RUN.

## Operation
- State codes decoded from `fsm_state`:
  - `4'h3` ATTACK_P1
  - `4'h4` ATTACK_P2
  - `4'h5` WAIT
  - `4'h6` CHECK
  - `4'h7` RANDOM
  - `4'h8` GAMEOVER
- `in_turn` = `fsm_state` ∈ {3, 4, 5}. All other codes are out of turn.
- Player register:
  - Loads `01` on any edge where `fsm_state` = 3.
  - Loads `10` on any edge where `fsm_state` = 4.
  - Holds otherwise, including through CHECK, RANDOM and GAMEOVER.
  - Result: the FSM's CHECK state sees the player who just attacked or timed out.
- Timer FSM, 3 states:
  - IDLE:
    - Prescaler = 0, `seconds_left` = `TURN_SECONDS`.
    - `in_turn` → RUN. The prescaler and seconds are reloaded on this same edge.
  - RUN:
    - Each edge: if prescaler = `CLK_HZ`-1, wrap to 0, decrement `seconds_left` and pulse `tick_1hz`. Otherwise increment the prescaler.
    - A decrement that reaches 0 → EXPIRED.
    - `!in_turn` → IDLE with reload. This has priority over a same-edge tick or expiry.
  - EXPIRED:
    - `timeout` = 1, `seconds_left` = 0.
    - Holds until `!in_turn`, then → IDLE.
- Player change while in RUN (edge where the player register takes a different value) → restart RUN with full reload. The state stays RUN.
- `fsm_state` toggling 3↔5 or 4↔5 does not reload; the countdown continues across WAIT.
- Unused codes (0–2, 9–15) are treated as out of turn.

## Timing
- Reset values:
  - timer FSM = IDLE
  - prescaler = 0
  - `seconds_left` = `TURN_SECONDS`
  - `current_player` = `00`
  - `timeout` = 0, `warn` = 0, `tick_1hz` = 0
- All outputs are registered or decoded from registered state only. There is no combinational path from `fsm_state` to any output.
- Latency from the first edge sampling `in_turn` to `timeout` high: 1 + `TURN_SECONDS`·`CLK_HZ` edges.
- `timeout` falls on the first edge sampling `!in_turn`.
- `current_player` updates one edge after `fsm_state` = 3 or 4 is presented.
- Reset asserted mid-turn: all outputs return to reset values immediately (asynchronous). The timer restarts only after `rst` deasserts and `in_turn` is sampled.

## Structure
- Package `game_pkg`, shared with the game FSM and the display path, holds:
  - FSM state code localparams (`S_ATTACK_P1` … `S_GAMEOVER`).
  - Player codes `P_NONE`, `P1`, `P2`.
  - Timer state enum `{T_IDLE, T_RUN, T_EXPIRED}`.
- Sub-module `tick_gen`:
  - Parameterised prescaler with a sync clear input and a one-cycle `tick` output.
  - Width is `$clog2(CLK_HZ)`.
  - Instantiated once.

## Test plan
All scenarios use `CLK_HZ`=4, `TURN_SECONDS`=3.
- Reset, `fsm_state`=0 held → `current_player`=00, `seconds_left`=3, `timeout`=0 indefinitely.
- `fsm_state`=3 held → `current_player`=01 after 1 edge; `seconds_left` 3→2→1→0 at edges 5, 9, 13; `timeout`=1 from edge 13; `warn`=1 throughout.
- `fsm_state` alternating 3,5,3,5… → behaves identically to the held-3 case (no reload); `timeout` at edge 13.
- `fsm_state`=4 for 6 edges, then 6 → `seconds_left` reloads to 3, `timeout`=0, `current_player` stays 10 during CHECK.
- Expired with `fsm_state`=5, then 7, then 6 → `timeout` drops on the first edge sampling 7; `current_player` unchanged.
- `rst` pulsed at edge 7 of a turn → all outputs reset asynchronously; after release with `fsm_state`=4, a full 13-edge countdown runs.
